// File: rtl/ssd_scan_driver.sv
// Memory-mapped seven-segment scan driver: data and control registers, a digit
// scanner, and a registered output stage for anodes, segments and decimal point.
module ssd_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              Addr,
  input  logic [31:0]       Write_data,
  output logic [31:0]       Read_data,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CTRL_W = 18;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CTRL_W-1:0] CTRL_RST = 18'h2_0000;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [31:0]       data_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  digit_idx;

  logic              lz_en;
  logic              disp_en;
  logic [3:0]        nibble;
  logic              blank_bit;
  logic              dp_bit;
  logic              upper_zero;
  logic              dark;
  logic [DIGITS-1:0] an_on;
  logic [6:0]        seg_on;
  logic              dp_on;

  // Active-high {g,f,e,d,c,b,a} hex font
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // CPU store path into data and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg <= 32'h0;
      ctrl_reg <= CTRL_RST;
    end else if (MemWrite) begin
      if (Addr) ctrl_reg <= Write_data[CTRL_W-1:0];
      else      data_reg <= Write_data;
    end
  end

  // Combinational readback of the addressed register
  assign Read_data = Addr ? {14'h0, ctrl_reg} : data_reg;

  // Dwell counter and digit pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  // Select the current digit's nibble/masks and decide whether it is dark
  always_comb begin
    lz_en      = ctrl_reg[16];
    disp_en    = ctrl_reg[17];
    nibble     = 4'h0;
    blank_bit  = 1'b0;
    dp_bit     = 1'b0;
    upper_zero = 1'b1;
    an_on      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        nibble    = data_reg[4*i +: 4];
        blank_bit = ctrl_reg[i];
        dp_bit    = ctrl_reg[8+i];
        an_on[i]  = 1'b1;
      end
      if (IDX_W'(i) >= digit_idx && data_reg[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    dark = !disp_en || blank_bit ||
           (lz_en && (digit_idx != '0) && upper_zero);
    seg_on = hex_font(nibble);
    dp_on  = dp_bit;
    if (dark) begin
      an_on  = '0;
      seg_on = 7'h00;
      dp_on  = 1'b0;
    end
  end

  // Registered pins with polarity applied
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= {DIGITS{AN_INV}};
      seg <= {7{SEG_INV}};
      dp  <= SEG_INV;
    end else begin
      an  <= an_on ^ {DIGITS{AN_INV}};
      seg <= seg_on ^ {7{SEG_INV}};
      dp  <= dp_on ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 4 digits, 4-cycle dwell, active-low pins.
module tb_ssd_scan_driver;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        Addr;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total;
  int passed;
  int edge_n;

  ssd_scan_driver #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .Addr(Addr),
    .Write_data(Write_data),
    .Read_data(Read_data),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] an_e,
                          input logic [6:0] seg_e, input logic dp_e);
    chk({tag, ".an"},  32'(an),  32'(an_e));
    chk({tag, ".seg"}, 32'(seg), 32'(seg_e));
    chk({tag, ".dp"},  32'(dp),  32'(dp_e));
  endtask

  // One active edge, then park on the following falling edge
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic goto_edge(input int k);
    while (edge_n < k) step();
  endtask

  task automatic wr(input logic a, input logic [31:0] v);
    MemWrite   = 1'b1;
    Addr       = a;
    Write_data = v;
    step();
    MemWrite   = 1'b0;
    Write_data = 32'h0;
  endtask

  task automatic rd(input string tag, input logic a, input logic [31:0] exp_v);
    Addr = a;
    #1;
    chk(tag, Read_data, exp_v);
  endtask

  initial begin
    total = 0; passed = 0; edge_n = 0;
    reset = 1'b0; MemWrite = 1'b0; Addr = 1'b0; Write_data = 32'h0;

    // Test 1: reset and idle release
    repeat (2) @(negedge clk);
    chk_pins("t1_in_reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b1;
    edge_n = 0;
    step();
    chk_pins("t1_digit0_zero", 4'hE, 7'h40, 1'b1);
    rd("t1_rd_data", 1'b0, 32'h0);
    rd("t1_rd_ctrl", 1'b1, 32'h0002_0000);

    // Test 2: 0x1234 scan sequence
    wr(1'b0, 32'h0000_1234);             // E2
    step();                              // E3
    chk_pins("t2_d0", 4'hE, 7'h19, 1'b1);
    goto_edge(5);
    chk_pins("t2_d1", 4'hD, 7'h30, 1'b1);
    goto_edge(9);
    chk_pins("t2_d2", 4'hB, 7'h24, 1'b1);
    goto_edge(13);
    chk_pins("t2_d3", 4'h7, 7'h79, 1'b1);
    goto_edge(16);
    chk_pins("t2_d3_last", 4'h7, 7'h79, 1'b1);
    goto_edge(17);
    chk_pins("t2_wrap_d0", 4'hE, 7'h19, 1'b1);

    // Test 3: leading-zero suppression and decimal point on digit 1
    wr(1'b0, 32'h0000_00AF);             // E18
    wr(1'b1, 32'h0003_0200);             // E19
    goto_edge(20);
    chk_pins("t3_d0", 4'hE, 7'h0E, 1'b1);
    rd("t3_rd_ctrl", 1'b1, 32'h0003_0200);
    rd("t3_rd_data", 1'b0, 32'h0000_00AF);
    goto_edge(21);
    chk_pins("t3_d1", 4'hD, 7'h08, 1'b0);
    goto_edge(25);
    chk_pins("t3_d2_dark", 4'hF, 7'h7F, 1'b1);
    goto_edge(29);
    chk_pins("t3_d3_dark", 4'hF, 7'h7F, 1'b1);

    // Test 4: blank digit 2
    goto_edge(32);
    wr(1'b0, 32'h0000_8888);             // E33
    wr(1'b1, 32'h0002_0004);             // E34
    goto_edge(35);
    chk_pins("t4_d0", 4'hE, 7'h00, 1'b1);
    goto_edge(37);
    chk_pins("t4_d1", 4'hD, 7'h00, 1'b1);
    goto_edge(41);
    chk_pins("t4_d2_blank", 4'hF, 7'h7F, 1'b1);
    goto_edge(45);
    chk_pins("t4_d3", 4'h7, 7'h00, 1'b1);

    // Test 5: global disable during digit 1, upper ctrl bits ignored
    goto_edge(53);
    wr(1'b1, 32'hFFFC_0000);             // E54
    goto_edge(55);
    chk_pins("t5_disabled", 4'hF, 7'h7F, 1'b1);
    rd("t5_rd_ctrl", 1'b1, 32'h0);
    goto_edge(58);
    wr(1'b1, 32'h0002_0000);             // E59
    chk_pins("t5_still_dark", 4'hF, 7'h7F, 1'b1);
    step();                              // E60
    chk_pins("t5_reenabled_d2", 4'hB, 7'h00, 1'b1);

    // Test 6: asynchronous reset in the middle of a digit-2 slot
    goto_edge(74);
    chk_pins("t6_pre_reset_d2", 4'hB, 7'h00, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_pins("t6_async_reset", 4'hF, 7'h7F, 1'b1);
    rd("t6_rd_data", 1'b0, 32'h0);
    rd("t6_rd_ctrl", 1'b1, 32'h0002_0000);
    repeat (2) @(negedge clk);
    chk_pins("t6_held", 4'hF, 7'h7F, 1'b1);
    reset = 1'b1;
    edge_n = 0;
    step();
    chk_pins("t6_restart_d0", 4'hE, 7'h40, 1'b1);
    goto_edge(4);
    chk_pins("t6_d0_last", 4'hE, 7'h40, 1'b1);
    goto_edge(5);
    chk_pins("t6_d1", 4'hD, 7'h40, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
